// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Two-port (CPU / DMA) arbiter in front of a single-ported data
//            memory; optional round-robin contention via DM_ARB_RR_EN.
// Revision : 1.0  initial release
// ============================================================================
module dm_arbiter #(
   parameter int MEM_WORDS = 3072
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wd0,
   input  logic [31:0] wd1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

   state_e      state_q;
   logic        owner_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wd_q;
   logic        gnt0_q;
   logic        gnt1_q;
   logic        rvalid0_q;
   logic        rvalid1_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        owner_d;
   logic        legal;
   logic        in_access;

`ifdef DM_ARB_RR_EN
   // 1 means port 1 was served last, so port 0 wins the next contention.
   logic        last_q;

   always_comb begin
      owner_d = 1'b0;
      if (req0 && req1)
         owner_d = ~last_q;
      else
         owner_d = ~req0;
   end
`else
   always_comb begin
      owner_d = ~req0;
   end
`endif

   assign legal     = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < c_MEM_WORDS);
   assign in_access = (state_q == ACCESS);

   // Memory side is masked by rst so an abandoned access can never write.
   assign mem_we   = we_q & in_access & legal & ~rst;
   assign mem_addr = (in_access && !rst) ? addr_q : 32'h0;
   assign mem_wd   = (in_access && !rst) ? wd_q   : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         wd_q      <= 32'h0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
`ifdef DM_ARB_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               rdata_q <= 32'h0;
               err_q   <= 1'b0;
               if (req0 || req1) begin
                  state_q <= ACCESS;
                  owner_q <= owner_d;
                  we_q    <= owner_d ? we1   : we0;
                  addr_q  <= owner_d ? addr1 : addr0;
                  wd_q    <= owner_d ? wd1   : wd0;
                  gnt0_q  <= ~owner_d;
                  gnt1_q  <= owner_d;
`ifdef DM_ARB_RR_EN
                  last_q  <= owner_d;
`endif
               end
            end
            ACCESS: begin
               state_q   <= IDLE;
               gnt0_q    <= 1'b0;
               gnt1_q    <= 1'b0;
               rvalid0_q <= ~owner_q;
               rvalid1_q <= owner_q;
               rdata_q   <= (legal && !we_q) ? mem_rd : 32'h0;
               err_q     <= ~legal;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata   = rdata_q;
   assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Directed self-checking bench for dm_arbiter with a behavioural
//            data memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_arbiter;

   localparam int MEM_WORDS = 3072;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wd0, wd1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
   logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [MEM_WORDS];
   logic [31:0] idx;

   always #5 clk = ~clk;

   dm_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .err(err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always_comb begin
      idx    = mem_addr >> 2;
      mem_rd = (idx < MEM_WORDS) ? mem[idx[11:0]] : 32'h0;
   end

   always @(posedge clk) begin
      if (mem_we && idx < MEM_WORDS) mem[idx[11:0]] <= mem_wd;
   end

   // Single-port transaction: drive, wait (bounded) for gnt, drop req, sample completion.
   task automatic run_txn(input bit port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output int nwe,
                          output logic rv, output logic [31:0] rd, output logic er);
      @(posedge clk); #1;
      if (port) begin req1 = 1; we1 = we; addr1 = addr; wd1 = wd; end
      else      begin req0 = 1; we0 = we; addr0 = addr; wd0 = wd; end
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         if (port ? gnt1 : gnt0) break;
         lat++;
      end
      nwe  = int'(mem_we);
      req0 = 0;
      req1 = 0;
      @(negedge clk);
      nwe += int'(mem_we);
      rv  = port ? (rvalid1 && !rvalid0) : (rvalid0 && !rvalid1);
      rd  = rdata;
      er  = err;
   endtask

   task automatic test_reset();
      rst = 1; req0 = 1; we0 = 1; addr0 = 32'h40; wd0 = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, err, mem_we, rdata, mem_addr, mem_wd} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b err=%b we=%b rdata=%h addr=%h wd=%h, want all 0",
                  gnt0, gnt1, rvalid0, rvalid1, err, mem_we, rdata, mem_addr, mem_wd);
      end
      @(posedge clk); #1;
      rst = 0; req0 = 0; we0 = 0;
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_edge_req_ignored: got gnt0=%b gnt1=%b, want 0 0", gnt0, gnt1);
      end
      checks++;
      if ({mem_we, mem_addr, mem_wd} !== '0) begin
         errors++;
         $display("FAIL idle_mem_outputs: got we=%b addr=%h wd=%h, want 0", mem_we, mem_addr, mem_wd);
      end
   endtask

   task automatic test_write_read();
      int lat, nwe; logic rv, er; logic [31:0] rd;
      run_txn(0, 1, 32'h10, 32'hDEADBEEF, lat, nwe, rv, rd, er);
      checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency: got %0d, want 1", lat); end
      checks++; if (nwe !== 1) begin errors++; $display("FAIL wr_mem_we_cycles: got %0d, want 1", nwe); end
      checks++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL wr_completion: got rv=%b err=%b rdata=%h, want 1 0 0", rv, er, rd);
      end
      checks++;
      if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_word: got %h, want deadbeef", mem[4]); end
      run_txn(0, 0, 32'h10, 32'h0, lat, nwe, rv, rd, er);
      checks++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'hDEADBEEF || nwe !== 0) begin
         errors++; $display("FAIL rd_back: got rv=%b err=%b rdata=%h nwe=%0d, want 1 0 deadbeef 0", rv, er, rd, nwe);
      end
      run_txn(1, 1, 32'h2FFC, 32'hCAFE_0001, lat, nwe, rv, rd, er);
      run_txn(1, 0, 32'h2FFC, 32'h0, lat, nwe, rv, rd, er);
      checks++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'hCAFE_0001) begin
         errors++; $display("FAIL last_word: got rv=%b err=%b rdata=%h, want 1 0 cafe0001", rv, er, rd);
      end
   endtask

   task automatic test_illegal();
      int lat, nwe; logic rv, er; logic [31:0] rd;
      run_txn(1, 1, 32'h3000, 32'h1234_5678, lat, nwe, rv, rd, er);
      checks++;
      if (nwe !== 0 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL out_of_range_wr: got nwe=%0d rv=%b err=%b rdata=%h, want 0 1 1 0", nwe, rv, er, rd);
      end
      run_txn(0, 0, 32'h12, 32'h0, lat, nwe, rv, rd, er);
      checks++;
      if (nwe !== 0 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL misaligned_rd: got nwe=%0d rv=%b err=%b rdata=%h, want 0 1 1 0", nwe, rv, er, rd);
      end
   endtask

   task automatic test_contention();
      logic [7:0] seq = '0;
      int n = 0, bad = 0;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      req0 = 1; we0 = 0; addr0 = 32'h10;
      req1 = 1; we1 = 0; addr1 = 32'h2FFC;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (gnt0 && gnt1) bad++;
         if (rvalid0 && rvalid1) bad++;
         if (gnt0 || gnt1) begin seq = {seq[6:0], gnt1}; n++; end
      end
      req0 = 0; req1 = 0;
      repeat (3) @(posedge clk);
`ifdef DM_ARB_RR_EN
      checks++;
      if (n !== 4 || seq[3:0] !== 4'b0101) begin
         errors++; $display("FAIL rr_grant_order: got n=%0d seq=%b, want 4 0101", n, seq[3:0]);
      end
`else
      checks++;
      if (n !== 4 || seq[3:0] !== 4'b0000) begin
         errors++; $display("FAIL fixed_grant_order: got n=%0d seq=%b, want 4 0000", n, seq[3:0]);
      end
`endif
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL one_hot_gnt_rvalid: got %0d violations, want 0", bad); end
   endtask

   task automatic test_rst_during_access();
      int lat, nwe, bad = 0; logic rv, er; logic [31:0] rd;
      run_txn(0, 1, 32'h20, 32'h1111_1111, lat, nwe, rv, rd, er);
      @(posedge clk); #1;
      req1 = 1; we1 = 1; addr1 = 32'h20; wd1 = 32'hBADB_AD00;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (gnt1 !== 1'b1) begin errors++; $display("FAIL rst_setup_gnt1: got %b, want 1", gnt1); end
      rst = 1;
      #1;
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b, want 0", mem_we); end
      req1 = 0; we1 = 0;
      @(posedge clk); #1;
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if ({gnt0, gnt1, rvalid0, rvalid1, err, mem_we, rdata, mem_addr, mem_wd} !== '0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL rst_abandon_outputs: got %0d nonzero cycles, want 0", bad); end
      checks++;
      if (mem[8] !== 32'h1111_1111) begin errors++; $display("FAIL rst_mem_word: got %h, want 11111111", mem[8]); end
      @(posedge clk); #1;
      req0 = 1; we0 = 0; addr0 = 32'h20;
      req1 = 1; we1 = 0; addr1 = 32'h10;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++; $display("FAIL post_rst_winner: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
      end
      req0 = 0; req1 = 0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
      rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
      test_reset();
      test_write_read();
      test_illegal();
      test_contention();
      test_rst_during_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 3072, SHALL set the number of 32-bit words in the attached data memory; legal word index is 0..MEM_WORDS-1.
REQ-002 clk  input  1  SHALL be the clock; all state updates on posedge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req0/req1  input  1 each  SHALL be the request from port 0 (CPU MEM stage) and port 1 (DMA/loader).
REQ-005 we0/we1  input  1 each  SHALL select write (1) or read (0) for that port's request.
REQ-006 addr0/addr1  input  32 each  SHALL be the byte address of the request.
REQ-007 wd0/wd1  input  32 each  SHALL be the write data of the request.
REQ-008 gnt0/gnt1  output  1 each  SHALL indicate the port's request was accepted and is in ACCESS.
REQ-009 rvalid0/rvalid1  output  1 each  SHALL be a one-cycle completion pulse to the owning port.
REQ-010 rdata  output  32  SHALL be the shared read-data bus, valid only while an rvalid is high.
REQ-011 err  output  1  SHALL flag a failed access, valid only while an rvalid is high.
REQ-012 mem_we  output  1  SHALL be the write enable to the data memory.
REQ-013 mem_addr  output  32  SHALL be the byte address to the data memory.
REQ-014 mem_wd  output  32  SHALL be the write data to the data memory.
REQ-015 mem_rd  input  32  SHALL be the combinational read data from the data memory at mem_addr.

Function
REQ-016 The FSM SHALL have two states, IDLE and ACCESS.
REQ-017 In IDLE with any req high, the block SHALL pick a winner (REQ-024/025), latch its we/addr/wd and port id, and enter ACCESS at the next edge.
REQ-018 In ACCESS, the block SHALL hold gnt of the owner high, drive mem_addr/mem_wd from the latched values, and return to IDLE at the next edge.
REQ-019 mem_we SHALL equal latched we AND state==ACCESS AND address legal AND !rst.
REQ-020 An address SHALL be legal iff addr[1:0]==0 and addr>>2 < MEM_WORDS; an illegal access SHALL perform no write.
REQ-021 At the edge leaving ACCESS, the block SHALL register rdata=mem_rd (0 if illegal or write) and err=!legal, then pulse the owner's rvalid for exactly the following cycle.
REQ-022 Latency: req sampled at edge N; gnt high during cycle N..N+1; rvalid high during cycle N+1..N+2; peak throughput is one access per 2 cycles.
REQ-023 Requesters SHALL hold req/we/addr/wd stable until gnt is seen; a req still high in the rvalid cycle SHALL be treated as a new request.
REQ-024 Only one gnt and at most one rvalid SHALL be high in any cycle; when neither req is high in IDLE, all memory-side outputs SHALL be 0.
REQ-025 Winner selection with both req high SHALL follow REQ-030/031; with one req high, that port SHALL win.

Reset
REQ-026 On rst, the state SHALL go to IDLE and gnt0/gnt1, rvalid0/rvalid1, err, rdata, mem_we, mem_addr, mem_wd SHALL become 0.
REQ-027 rst during ACCESS SHALL abandon the access: no write at that edge, no rvalid afterwards.
REQ-028 The round-robin pointer SHALL reset to "port 1 last served", so port 0 wins first.
REQ-029 Requests sampled on the rst edge SHALL be ignored.

Configuration
REQ-030 With DM_ARB_RR_EN defined, a two-way contention SHALL grant the port not served last; the pointer SHALL update on every grant.
REQ-031 Without DM_ARB_RR_EN, port 0 SHALL always win contention and no pointer SHALL exist.

Verification
REQ-032 Port0 write addr=0x10, wd=0xDEADBEEF, then read addr=0x10 -> mem_we one cycle, second rvalid0 with rdata=0xDEADBEEF, err=0.
REQ-033 req0 and req1 held high for 8 cycles with RR_EN -> grants 0,1,0,1; without RR_EN -> grants 0,0,0,0.
REQ-034 Port1 write addr=0x3000 (MEM_WORDS=3072) -> mem_we stays 0, rvalid1 with err=1, rdata=0.
REQ-035 Port0 read addr=0x12 (misaligned) -> no write, rvalid0 with err=1, rdata=0.
REQ-036 rst asserted during ACCESS of port1 write addr=0x20 -> memory word unchanged, no rvalid1, all outputs 0, next contention grants port 0.
